// File: rtl/accel_spi_ctrl_pkg.sv
// accel_pkg: register map, init/read tables, FSM states and tx word builder for the accelerometer SPI controller
package accel_pkg;
  localparam int TIMEOUT_DEF = 255;
  localparam logic [5:0] REG_BW_RATE     = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;
  localparam logic [5:0] REG_DATAX1      = 6'h33;
  localparam logic [5:0] REG_DATAY0      = 6'h34;
  localparam logic [5:0] REG_DATAY1      = 6'h35;
  localparam logic [3:0][5:0] INIT_ADDR = {6'h00, REG_POWER_CTL, REG_BW_RATE, REG_DATA_FORMAT};
  localparam logic [3:0][7:0] INIT_DATA = {8'h00, 8'h08, 8'h0A, 8'h08};
  localparam logic [3:0][5:0] RD_ADDR = {REG_DATAY1, REG_DATAY0, REG_DATAX1, REG_DATAX0};
  typedef enum logic [2:0] {
    INIT_ISSUE,
    INIT_WAIT,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    PUBLISH
  } state_t;
  function automatic logic [15:0] tx_word(input logic rd, input logic [1:0] idx);
    return rd ? {2'b10, RD_ADDR[idx], 8'h00} : {2'b00, INIT_ADDR[idx], INIT_DATA[idx]};
  endfunction
endpackage

// File: rtl/accel_spi_ctrl.sv
// accel_spi_ctrl: configures the accelerometer, then reads X/Y on request via an external serialiser
module accel_spi_ctrl
  import accel_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic        spi_clk,
  input  logic        reset,
  input  logic        sample_tick,
  output logic        ser_start,
  output logic [15:0] ser_data_tx,
  input  logic        ser_done,
  input  logic [7:0]  ser_data_rx,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic        data_valid,
  output logic        init_done,
  output logic        busy,
  output logic        timeout_err
);
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic pending, pending_n, armed, is_issue, is_wait, timed_out;
  logic [15:0] tcnt, tx_q;
  logic [3:0][7:0] rx_b;
  assign is_issue = state == INIT_ISSUE || state == RD_ISSUE;
  assign is_wait = state == INIT_WAIT || state == RD_WAIT;
  assign timed_out = is_wait && !ser_done && tcnt == 16'(TIMEOUT_CYC - 1);
  assign ser_start = is_issue && armed;
  assign ser_data_tx = ser_start ? tx_word(state == RD_ISSUE, idx) : tx_q;
  assign busy = state != IDLE || pending;
  // state register; armed keeps the first start out of the reset cycles
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state <= INIT_ISSUE;
      idx <= 2'd0;
      pending <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      pending <= pending_n;
      armed <= 1'b1;
    end
  end
  // next state, step index and coalesced sample request
  always_comb begin
    state_n = state;
    idx_n = idx;
    pending_n = pending | (sample_tick && init_done && state != IDLE);
    unique case (state)
      INIT_ISSUE, RD_ISSUE: state_n = armed ? (state == RD_ISSUE ? RD_WAIT : INIT_WAIT) : state;
      INIT_WAIT: begin
        state_n = ser_done ? (idx == 2'd2 ? IDLE : INIT_ISSUE) : timed_out ? INIT_ISSUE : state;
        idx_n = ser_done ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : idx;
      end
      RD_WAIT: begin
        state_n = ser_done ? (idx == 2'd3 ? PUBLISH : RD_ISSUE) : timed_out ? RD_ISSUE : state;
        idx_n = ser_done ? idx + 2'd1 : idx;
      end
      IDLE: begin
        state_n = (sample_tick || pending) ? RD_ISSUE : IDLE;
        idx_n = 2'd0;
        pending_n = 1'b0;
      end
      PUBLISH: begin
        state_n = pending ? RD_ISSUE : IDLE;
        idx_n = 2'd0;
        pending_n = pending ? 1'b0 : pending_n;
      end
      default: state_n = INIT_ISSUE;
    endcase
  end
  // timeout counter, held tx word, read bytes and published outputs
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      tcnt <= '0;
      tx_q <= '0;
      rx_b <= '0;
      accel_x <= '0;
      accel_y <= '0;
      data_valid <= 1'b0;
      init_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= is_wait && !timed_out ? tcnt + 16'd1 : '0;
      if (ser_start) tx_q <= ser_data_tx;
      if (state == RD_WAIT && ser_done) rx_b[idx] <= ser_data_rx;
      data_valid <= state == PUBLISH;
      if (state == PUBLISH) begin
        accel_x <= {rx_b[1], rx_b[0]};
        accel_y <= {rx_b[3], rx_b[2]};
      end
      if (state == INIT_WAIT && ser_done && idx == 2'd2) init_done <= 1'b1;
      if (timed_out) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_accel_spi_ctrl.sv
// tb_accel_spi_ctrl: scoreboard bench with a serialiser model answering 20 cycles after each start
module tb_accel_spi_ctrl;
  localparam int TO = 255;
  logic spi_clk = 1'b0, reset = 1'b1, sample_tick = 1'b0, stray = 1'b0;
  logic ser_start, ser_done, data_valid, init_done, busy, timeout_err;
  logic [15:0] ser_data_tx, accel_x, accel_y;
  logic [7:0] ser_data_rx;
  logic [7:0] rxv [4];
  logic [15:0] hold_word, px = '0, py = '0;
  logic holding = 1'b0, active = 1'b0;
  logic [5:0] maddr;
  int mcnt, cyc = 0, done_cyc = 0, starts = 0, dv_cnt = 0, drop_req = 0, drop_done = 0;
  int compared = 0, mismatched = 0;
  logic [15:0] txq [$];
  logic [31:0] sampq [$];
  int start_cyc [$];

  accel_spi_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .spi_clk(spi_clk), .reset(reset), .sample_tick(sample_tick),
    .ser_start(ser_start), .ser_data_tx(ser_data_tx), .ser_done(ser_done),
    .ser_data_rx(ser_data_rx), .accel_x(accel_x), .accel_y(accel_y),
    .data_valid(data_valid), .init_done(init_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 spi_clk = ~spi_clk;
  always @(posedge spi_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // serialiser model: done 20 cycles after start, optionally swallowing a read start
  always @(posedge spi_clk) begin
    if (reset) begin
      active <= 1'b0;
      ser_done <= 1'b0;
      ser_data_rx <= '0;
      mcnt <= 0;
    end else begin
      ser_done <= stray;
      if (ser_start) begin
        maddr <= ser_data_tx[13:8];
        mcnt <= 1;
        if (drop_req != drop_done && ser_data_tx[15]) begin
          active <= 1'b0;
          drop_done <= drop_done + 1;
        end else active <= 1'b1;
      end else if (active) begin
        mcnt <= mcnt + 1;
        if (mcnt == 19) begin
          active <= 1'b0;
          ser_done <= 1'b1;
          ser_data_rx <= rxv[maddr[1:0] - 2'd2];
        end
      end
    end
  end

  // monitor: scoreboard pops on start and data_valid, tx hold and output stability checks
  always @(negedge spi_clk) begin
    if (!reset && ser_start) begin
      starts <= starts + 1;
      start_cyc.push_back(cyc);
      hold_word <= ser_data_tx;
      holding <= 1'b1;
      chk("start_expected", 32'(txq.size() != 0), 1);
      if (txq.size() != 0) chk("tx_word", 32'(ser_data_tx), 32'(txq.pop_front()));
    end else if (!reset && holding) chk("tx_hold", 32'(ser_data_tx), 32'(hold_word));
    if (ser_done) begin
      holding <= 1'b0;
      done_cyc <= cyc;
    end
    if (reset) holding <= 1'b0;
    if (data_valid) begin
      dv_cnt <= dv_cnt + 1;
      chk("dv_expected", 32'(sampq.size() != 0), 1);
      if (sampq.size() != 0) chk("sample_xy", {accel_x, accel_y}, sampq.pop_front());
    end else if (!reset && (accel_x !== px || accel_y !== py))
      chk("accel_stable", {accel_x, accel_y}, {px, py});
    px <= accel_x;
    py <= accel_y;
  end

  task automatic tick();
    sample_tick = 1'b1;
    @(negedge spi_clk);
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge spi_clk);
  endtask

  task automatic wait_init(input int lim);
    int n = 0;
    while (!init_done && n < lim) begin
      @(negedge spi_clk);
      n++;
    end
    chk("init_wait", 32'(init_done), 1);
    chk("init_rise", 32'(cyc), 32'(done_cyc + 1));
    chk("init_txq_empty", 32'(txq.size()), 0);
  endtask

  task automatic wait_samples(input int lim);
    int n = 0;
    while (sampq.size() != 0 && n < lim) begin
      @(negedge spi_clk);
      n++;
    end
    chk("sample_wait", 32'(sampq.size()), 0);
  endtask

  task automatic push_reads();
    txq.push_back(16'hB200);
    txq.push_back(16'hB300);
    txq.push_back(16'hB400);
    txq.push_back(16'hB500);
  endtask

  task automatic check_reset_state();
    chk("rst_start", 32'(ser_start), 0);
    chk("rst_tx", 32'(ser_data_tx), 0);
    chk("rst_x", 32'(accel_x), 0);
    chk("rst_y", 32'(accel_y), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_init", 32'(init_done), 0);
    chk("rst_terr", 32'(timeout_err), 0);
  endtask

  initial begin
    int b, dv0, n;
    rxv = '{8'h34, 8'h12, 8'hCE, 8'hFF};
    repeat (3) @(negedge spi_clk);
    check_reset_state();
    txq.push_back(16'h3108);
    txq.push_back(16'h2C0A);
    txq.push_back(16'h2D08);
    reset = 1'b0;
    idle(5);
    tick();
    wait_init(200);
    chk("idle_busy", 32'(busy), 0);
    chk("early_tick_dv", 32'(dv_cnt), 0);
    idle(30);
    chk("early_tick_starts", 32'(starts), 3);
    push_reads();
    sampq.push_back({16'h1234, 16'hFFCE});
    tick();
    chk("busy_read", 32'(busy), 1);
    wait_samples(300);
    idle(3);
    chk("x_held", 32'(accel_x), 32'h1234);
    chk("y_held", 32'(accel_y), 32'hFFCE);
    stray = 1'b1;
    @(negedge spi_clk);
    stray = 1'b0;
    idle(30);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_starts", 32'(starts), 7);
    rxv = '{8'h01, 8'h80, 8'hFF, 8'h7F};
    dv0 = dv_cnt;
    push_reads();
    push_reads();
    sampq.push_back({16'h8001, 16'h7FFF});
    sampq.push_back({16'h8001, 16'h7FFF});
    tick();
    idle(10);
    tick();
    idle(20);
    tick();
    idle(20);
    tick();
    wait_samples(500);
    idle(100);
    chk("coalesce_dv", 32'(dv_cnt - dv0), 2);
    chk("coalesce_txq", 32'(txq.size()), 0);
    chk("terr_clear", 32'(timeout_err), 0);
    rxv = '{8'h34, 8'h12, 8'hCE, 8'hFF};
    b = start_cyc.size();
    drop_req = drop_req + 1;
    txq.push_back(16'hB200);
    push_reads();
    sampq.push_back({16'h1234, 16'hFFCE});
    tick();
    wait_samples(800);
    chk("terr_set", 32'(timeout_err), 1);
    chk("retry_gap", 32'(start_cyc[b+1] - start_cyc[b]), 32'(TO + 1));
    b = starts;
    txq.push_back(16'hB200);
    txq.push_back(16'hB300);
    txq.push_back(16'hB400);
    tick();
    n = 0;
    while (starts != b + 3 && n < 200) begin
      @(negedge spi_clk);
      n++;
    end
    chk("third_read", 32'(starts), 32'(b + 3));
    idle(5);
    reset = 1'b1;
    @(negedge spi_clk);
    check_reset_state();
    idle(2);
    txq.push_back(16'h3108);
    txq.push_back(16'h2C0A);
    txq.push_back(16'h2D08);
    reset = 1'b0;
    wait_init(200);
    chk("final_samples", 32'(sampq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end
endmodule
